relu_maxpool_2x2: RTL



---
 rtl/nne_pkg.sv | 9 +
 rtl/pool_line_buffer.sv | 22 ++
 rtl/relu_maxpool_2x2.sv | 124 ++++++++++++
 3 files changed

// File: rtl/nne_pkg.sv
// nne_pkg: shared pixel width, pooling FSM states and signed-max helper
package nne_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int SMAX_W = 64;
  typedef enum logic [1:0] {S_EVEN_A, S_EVEN_B, S_ODD_A, S_ODD_B} pool_state_t;
  function automatic logic signed [SMAX_W-1:0] smax(input logic signed [SMAX_W-1:0] a, input logic signed [SMAX_W-1:0] b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/pool_line_buffer.sv
// pool_line_buffer: register array with one write port and one combinational read port
module pool_line_buffer
  import nne_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  // storage is never read before written, so it carries no reset
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/relu_maxpool_2x2.sv
// relu_maxpool_2x2: streaming 2x2 stride-2 signed max-pool; MAXPOOL_LAST_EN adds Last_Out end-of-frame flag
module relu_maxpool_2x2
  import nne_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] Data_In,
  input  logic              Valid_In,
  output logic [DATA_W-1:0] Data_Out,
  output logic              Valid_Out
`ifdef MAXPOOL_LAST_EN
  ,
  output logic              Last_Out
`endif
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int AW = IMG_W > 2 ? $clog2(IMG_W / 2) : 1;
  if (IMG_W < 2 || IMG_W % 2 != 0) begin : g_bad_w
    $error("relu_maxpool_2x2: IMG_W must be even and >= 2");
  end
  if (IMG_H < 2 || IMG_H % 2 != 0) begin : g_bad_h
    $error("relu_maxpool_2x2: IMG_H must be even and >= 2");
  end
  if (DATA_W > SMAX_W) begin : g_bad_dw
    $error("relu_maxpool_2x2: DATA_W exceeds signed-max width");
  end
  function automatic logic [DATA_W-1:0] mx(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return DATA_W'(smax(SMAX_W'($signed(a)), SMAX_W'($signed(b))));
  endfunction
  pool_state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [DATA_W-1:0] pair_q, pair_d, data_q, data_d, lb_rdata, hmax, wmax;
  logic valid_q, valid_d, lb_we, eol, eof;
  logic [AW-1:0] lb_addr;
  assign eol = col_q == CW'(IMG_W - 1);
  assign eof = eol && row_q == RW'(IMG_H - 1);
  assign lb_addr = AW'(col_q >> 1);
  assign hmax = mx(pair_q, Data_In);
  assign wmax = mx(hmax, lb_rdata);
  pool_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W / 2), .AW(AW)) u_lb (
    .clk    (clk),
    .we_i   (lb_we),
    .waddr_i(lb_addr),
    .wdata_i(hmax),
    .raddr_i(lb_addr),
    .rdata_o(lb_rdata)
  );
`ifdef MAXPOOL_LAST_EN
  logic last_q, last_d;
  assign Last_Out = last_q;
`endif
  // next-state: everything advances only on accepted pixels
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    row_d = row_q;
    pair_d = pair_q;
    data_d = data_q;
    valid_d = 1'b0;
    lb_we = 1'b0;
`ifdef MAXPOOL_LAST_EN
    last_d = 1'b0;
`endif
    if (Valid_In) begin
      col_d = eol ? '0 : col_q + 1'b1;
      row_d = eol ? (eof ? '0 : row_q + 1'b1) : row_q;
      case (state_q)
        S_EVEN_A: begin
          pair_d = Data_In;
          state_d = S_EVEN_B;
        end
        S_EVEN_B: begin
          lb_we = 1'b1;
          state_d = eol ? S_ODD_A : S_EVEN_A;
        end
        S_ODD_A: begin
          pair_d = Data_In;
          state_d = S_ODD_B;
        end
        S_ODD_B: begin
          data_d = wmax;
          valid_d = 1'b1;
`ifdef MAXPOOL_LAST_EN
          last_d = eof;
`endif
          state_d = eol ? S_EVEN_A : S_ODD_A;
        end
        default: state_d = S_EVEN_A;
      endcase
    end
  end
  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EVEN_A;
      col_q <= '0;
      row_q <= '0;
      pair_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
`ifdef MAXPOOL_LAST_EN
      last_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      pair_q <= pair_d;
      data_q <= data_d;
      valid_q <= valid_d;
`ifdef MAXPOOL_LAST_EN
      last_q <= last_d;
`endif
    end
  end
  assign Data_Out = data_q;
  assign Valid_Out = valid_q;
endmodule
